// File: rtl/ps2_keyboard_fifo.sv
// Memory-mapped PS/2 keyboard receiver with scancode FIFO, frame watchdog and sticky status flags.
// Optional odd-parity checking is enabled by defining KEYBOARD_PARITY_CHECK_EN.
module ps2_keyboard_fifo #(
   parameter logic [63:0] BASE_ADDR      = 64'h0000_0000_0000_F000,
   parameter int          FIFO_DEPTH     = 16,
   parameter int          SYNC_STAGES    = 2,
   parameter int          TIMEOUT_CYCLES = 50000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] address,
   input  logic [63:0] data_in,
   input  logic        read,
   input  logic        write,
   input  logic        PS2_clk,
   input  logic        PS2_data,
   output logic [63:0] data_out,
   output logic        data_drive,
   output logic        irq
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = AW + 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_MAX      = WD_W'(TIMEOUT_CYCLES);
   localparam logic [63:0]     STATUS_ADDR = BASE_ADDR + 64'd8;

   typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_CHECK} state_t;
   state_t r_state, w_state_next;

   logic [SYNC_STAGES-1:0] r_clk_sync, r_data_sync;
   logic                   r_clk_prev;
   logic [3:0]             r_bit_cnt;
   logic [9:0]             r_shift;
   logic [WD_W-1:0]        r_wdog;
   logic [7:0]             r_mem [FIFO_DEPTH];
   logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]       r_count;
   logic                   r_overflow, r_parity_err;

   logic w_fall, w_bit, w_par_ok, w_accept, w_par_err_set;
   logic w_empty, w_full, w_sel_data, w_sel_stat, w_pop, w_push, w_ovf_set;
   logic w_unused;

   assign w_fall = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
   assign w_bit  = r_data_sync[SYNC_STAGES-1];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_clk_sync  <= '1;
         r_data_sync <= '1;
         r_clk_prev  <= 1'b1;
      end else begin
         r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], PS2_clk};
         r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], PS2_data};
         r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_fall && !w_bit) w_state_next = ST_RECV;
         ST_RECV: begin
            if (r_wdog == WD_MAX)                w_state_next = ST_IDLE;
            else if (w_fall && r_bit_cnt == 4'd10) w_state_next = ST_CHECK;
         end
         ST_CHECK: w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Bits shift in from the top so that after the stop bit r_shift = {stop, parity, scancode}.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_bit_cnt <= 4'd0;
         r_shift   <= 10'd0;
         r_wdog    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_wdog <= '0;
               if (w_fall && !w_bit) r_bit_cnt <= 4'd1;
            end
            ST_RECV: begin
               if (w_fall) begin
                  r_shift   <= {w_bit, r_shift[9:1]};
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                  r_wdog    <= '0;
               end else begin
                  r_wdog <= r_wdog + WD_W'(1);
               end
            end
            default: begin
               r_bit_cnt <= 4'd0;
               r_wdog    <= '0;
            end
         endcase
      end
   end

   assign w_par_ok = ^r_shift[8:0];

`ifdef KEYBOARD_PARITY_CHECK_EN
   assign w_accept      = (r_state == ST_CHECK) && r_shift[9] && w_par_ok;
   assign w_par_err_set = (r_state == ST_CHECK) && !w_par_ok;
   assign w_unused      = ^{data_in[63:4], data_in[1:0]};
`else
   assign w_accept      = (r_state == ST_CHECK) && r_shift[9];
   assign w_par_err_set = 1'b0;
   assign w_unused      = ^{data_in[63:4], data_in[1:0], w_par_ok};
`endif

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_sel_data = (address == BASE_ADDR);
   assign w_sel_stat = (address == STATUS_ADDR);
   assign w_pop      = read && w_sel_data && !w_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign w_push     = w_accept && (!w_full || w_pop);
   assign w_ovf_set  = w_accept && w_full && !w_pop;

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= r_shift[7:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_overflow   <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_ovf_set)                              r_overflow <= 1'b1;
         else if (write && w_sel_stat && data_in[2]) r_overflow <= 1'b0;
         if (w_par_err_set)                          r_parity_err <= 1'b1;
         else if (write && w_sel_stat && data_in[3]) r_parity_err <= 1'b0;
      end
   end

   always_comb begin
      data_out = 64'd0;
      if (read && w_sel_data && !w_empty)
         data_out = {55'd0, 1'b1, r_mem[r_rd_ptr]};
      else if (read && w_sel_stat)
         data_out = {48'd0, 8'(r_count), 4'd0, r_parity_err, r_overflow, w_full, !w_empty};
   end

   assign data_drive = read && (w_sel_data || w_sel_stat);
   assign irq        = !w_empty;

endmodule

// File: doc/ps2_keyboard_fifo.md
Name: ps2_keyboard_fifo

Overview:
Memory-mapped PS/2 keyboard receiver for the single-cycle core's 64-bit data/address bus. It supersedes the fixed keyboard peripheral with a configurable base address, a configurable scancode FIFO depth, a frame watchdog and sticky status flags. It receives 11-bit PS/2 device-to-host frames and queues the scancodes. The CPU reads them through two bus registers.

Parameters:
BASE_ADDR, 64'h0000_0000_0000_F000, byte address of the DATA register; STATUS is at BASE_ADDR+8
FIFO_DEPTH, 16, scancode FIFO entries; must be a power of two, 2..256
SYNC_STAGES, 2, flip-flop stages on PS2_clk and PS2_data; minimum 2
TIMEOUT_CYCLES, 50000, system clocks allowed without a PS/2 falling edge mid-frame before the frame is abandoned

Ports:
clock  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high
address  input  64  bus address
data_in  input  64  bus write data
read  input  1  bus read strobe
write  input  1  bus write strobe
PS2_clk  input  1  asynchronous PS/2 clock
PS2_data  input  1  asynchronous PS/2 data
data_out  output  64  read data; zero when this block is not selected
data_drive  output  1  high when read=1 and address equals BASE_ADDR or BASE_ADDR+8
irq  output  1  high while the FIFO is not empty

Behaviour:
- Reset: FIFO empty, count 0, sticky flags 0, receiver in IDLE, bit counter 0, watchdog 0, sync chains loaded with 1. data_out=0, data_drive=0, irq=0.
- Synchronisation: both PS/2 lines pass through SYNC_STAGES flops. A falling edge means the last synced PS2_clk sample was 1 and the current one is 0. Data is sampled on that edge.
- Receiver FSM:
  - IDLE: on a falling edge with data=0 (start bit), go to RECV with bit counter 1. A falling edge with data=1 is ignored.
  - RECV: shift in bits 1..8 LSB-first as the scancode, then bit 9 (odd parity), then bit 10 (stop). After bit 10, go to CHECK.
  - CHECK (one cycle): the frame is accepted when stop=1 and parity is valid (see Optional Feature). An accepted frame is pushed to the FIFO. Next state is IDLE in all cases.
- Watchdog: counts system clocks in RECV and clears on every falling edge. On reaching TIMEOUT_CYCLES it forces IDLE, discards the partial frame and sets no flag.
- DATA register, read:
  - data_out = {55'b0, valid, scancode}, where valid=1 when the FIFO is not empty.
  - data_out is combinational, in the same cycle as read.
  - The head entry is popped at the end of the cycle if the FIFO was not empty.
  - Reading an empty FIFO returns 0 and changes no state.
- STATUS register, read: data_out = {48'b0, count[7:0], 4'b0, parity_err, overflow, full, not_empty}. count saturates its representation at FIFO_DEPTH (256 encodes as 0 only when FIFO_DEPTH=256).
- STATUS register, write: write-1-to-clear. data_in[2] clears overflow and data_in[3] clears parity_err. Writes to DATA are ignored.
- FIFO boundaries:
  - Push when full with no pop: the new scancode is dropped and overflow is set.
  - Push and pop in the same cycle: both occur (including when full), count is unchanged, no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- Same-cycle flag events: if a flag is being set in the same cycle a write-1-to-clear hits it, set wins.
- Reset mid-frame: the partial frame is discarded and the FIFO contents are lost.
- Read and write both asserted to a register in one cycle: treated as a read followed by the write effect; both take effect at the edge.

Optional Feature:
KEYBOARD_PARITY_CHECK_EN.
- Defined: a frame whose 9 bits (data plus parity) have an even count of 1s is dropped and sets parity_err.
- Undefined: the parity bit is ignored, every frame with stop=1 is accepted, and parity_err reads 0.

Test Plan:
- Send frame for 0x1C (start 0, bits 0011_1000 LSB-first, parity 0, stop 1) -> irq=1; STATUS=0x0101; read DATA -> 0x11C; next read -> 0x000; irq=0.
- With FIFO_DEPTH=4, send 5 frames (0x01..0x05) -> STATUS full=1, overflow=1, count=4; reads return 0x101,0x102,0x103,0x104; write STATUS data_in=0x4 -> overflow=0.
- FIFO full, CPU reads DATA in the same cycle CHECK pushes 0x2A -> no overflow, count stays 4, 0x2A is last out.
- Send 0x1C with parity=1 -> with KEYBOARD_PARITY_CHECK_EN: FIFO empty, parity_err=1; without: DATA reads 0x11C.
- Send start plus 4 bits, then hold PS2_clk high for TIMEOUT_CYCLES+1 clocks, then a full frame 0x5A -> only 0x15A is queued.
- Assert reset while 6 bits in and 2 entries queued -> STATUS=0, irq=0; the next full frame 0x29 reads back as 0x129.
